// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared constants for the GPIO controller.
//   - REG_* : 3-bit word index of each register inside the 32-byte window
//   - ST_*  : bus FSM state encoding
//   - lane_mask() : expands 4 byte strobes into a 32-bit bit mask
package gpio_ctrl_pkg;

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_SET    = 3'd3;
  localparam logic [2:0] REG_CLR    = 3'd4;
  localparam logic [2:0] REG_TGL    = 3'd5;
  localparam logic [2:0] REG_IRQ_EN = 3'd6;
  localparam logic [2:0] REG_IRQ_ST = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  function automatic logic [31:0] lane_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: native memory bus of the riscv core.
//   mem_valid/mem_addr/mem_wdata/mem_wstrb : master -> slave request
//   mem_ready/mem_rdata                    : slave -> master acknowledge
interface gpio_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/gpio_sync.sv
// gpio_sync: two-flop synchronizer for asynchronous pad inputs plus a
// one-cycle history register for rising-edge detection.
//   clk, resetn : clock, asynchronous active-low reset
//   gpio_in     : raw pad inputs
//   sync        : synchronized inputs (second flop)
//   rise        : one-cycle pulse per bit on a synchronized 0->1 transition
module gpio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign sync = sync2;
  assign rise = sync2 & ~prev;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO controller on the riscv native bus.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : slave side of the memory bus (valid/addr/wdata/wstrb in,
//                 ready/rdata out); one-cycle ack, one ack per two cycles
//   gpio_in     : asynchronous pad inputs
//   gpio_out    : output register
//   gpio_oe     : direction, 1 = drive
//   irq         : level interrupt, |(IRQ_ST & IRQ_EN)
// Only addresses inside the 32-byte window at ADDR_BASE are answered.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] ADDR_BASE = 32'h0000_1000
) (
  input  logic             clk,
  input  logic             resetn,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  logic [0:0]       state;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_rise;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_st;
  logic [WIDTH-1:0] irq_st_nxt;
  logic [WIDTH-1:0] w1c_bits;
  logic [31:0]      lane_m;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wbits;
  logic [2:0]       reg_idx;
  logic             hit;
  logic             accept;
  logic             wr;
  logic [31:0]      rd_word;
  logic             unused_bits;

  gpio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .gpio_in (gpio_in),
    .sync    (in_sync),
    .rise    (in_rise)
  );

  assign hit     = (bus.mem_addr[31:5] == ADDR_BASE[31:5]);
  assign reg_idx = bus.mem_addr[4:2];
  // mem_valid is only looked at in IDLE, so a request held through ACK
  // cannot be accepted a second time.
  assign accept  = (state == ST_IDLE) && bus.mem_valid && hit;
  assign wr      = accept && (bus.mem_wstrb != 4'b0000);

  assign lane_m  = lane_mask(bus.mem_wstrb);
  assign wmask   = lane_m[WIDTH-1:0];
  assign wbits   = bus.mem_wdata[WIDTH-1:0] & wmask;

  // A new edge overrides a W1C clear of the same bit in the same cycle.
  always_comb begin
    w1c_bits   = '0;
    if (wr && (reg_idx == REG_IRQ_ST)) w1c_bits = wbits;
    irq_st_nxt = (irq_st & ~w1c_bits) | in_rise;
  end

  always_comb begin
    rd_word = '0;
    case (reg_idx)
      REG_OUT:    rd_word[WIDTH-1:0] = gpio_out;
      REG_DIR:    rd_word[WIDTH-1:0] = gpio_oe;
      REG_IN:     rd_word[WIDTH-1:0] = in_sync;
      REG_IRQ_EN: rd_word[WIDTH-1:0] = irq_en;
      REG_IRQ_ST: rd_word[WIDTH-1:0] = irq_st;
      default:    rd_word = '0;
    endcase
  end

  // Bus FSM: IDLE -> ACK on an accepted hit, ACK -> IDLE unconditionally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      state         <= accept ? ST_ACK : ST_IDLE;
      bus.mem_ready <= accept;
      bus.mem_rdata <= (accept && !wr) ? rd_word : 32'h0;
    end
  end

  // Register file; writes commit on the accepting edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio_out <= '0;
      gpio_oe  <= '0;
      irq_en   <= '0;
      irq_st   <= '0;
    end else begin
      irq_st <= irq_st_nxt;
      if (wr) begin
        case (reg_idx)
          REG_OUT:    gpio_out <= (gpio_out & ~wmask) | wbits;
          REG_DIR:    gpio_oe  <= (gpio_oe & ~wmask) | wbits;
          REG_SET:    gpio_out <= gpio_out | wbits;
          REG_CLR:    gpio_out <= gpio_out & ~wbits;
          REG_TGL:    gpio_out <= gpio_out ^ wbits;
          REG_IRQ_EN: irq_en   <= (irq_en & ~wmask) | wbits;
          default:    ;
        endcase
      end
    end
  end

  assign irq = |(irq_st & irq_en);

  // Address byte offset and data bits above WIDTH have no function.
  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, lane_m};

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed bench for gpio_ctrl with a read-data scoreboard.
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;

  localparam int          WIDTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  gpio_ctrl_if bus ();

  gpio_ctrl #(.WIDTH(WIDTH), .ADDR_BASE(BASE)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every acknowledge pops one expected read word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (resetn && bus.mem_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", bus.mem_rdata, e);
        end
      end
    end
  end

  // One bus transfer; exp is the read data the master should see (0 for writes).
  task automatic xfer(input logic [4:0] off, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] exp);
    int  n;
    bit  got;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + {27'd0, off};
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    exp_q.push_back(exp);
    n   = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.mem_ready) got = 1'b1;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    if (!got) void'(exp_q.pop_back());
    chk("ready_latency", n, 1);
    @(posedge clk);
    #1;
    chk("ready_one_cycle", {31'd0, bus.mem_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    resetn        = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    gpio_in       = WIDTH'($urandom);
    repeat (4) @(posedge clk);
    gpio_in = WIDTH'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    gpio_in = '0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_out", {24'd0, gpio_out}, 32'd0);
    chk("rst_oe", {24'd0, gpio_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    xfer(5'h1C, 32'd0, 4'b0000, 32'h0);
    xfer(5'h08, 32'd0, 4'b0000, 32'h0);

    // OUT / SET / CLR / TGL
    xfer(5'h00, 32'h0000_00A5, 4'b0001, 32'h0);
    chk("out_a5", {24'd0, gpio_out}, 32'hA5);
    xfer(5'h0C, 32'h0000_000F, 4'b0001, 32'h0);
    chk("set_af", {24'd0, gpio_out}, 32'hAF);
    xfer(5'h10, 32'h0000_0081, 4'b0001, 32'h0);
    chk("clr_2e", {24'd0, gpio_out}, 32'h2E);
    xfer(5'h14, 32'h0000_00FF, 4'b0001, 32'h0);
    chk("tgl_d1", {24'd0, gpio_out}, 32'hD1);
    xfer(5'h00, 32'd0, 4'b0000, 32'hD1);
    xfer(5'h0C, 32'd0, 4'b0000, 32'h0);

    // DIR and byte strobes
    xfer(5'h04, 32'h0000_00FF, 4'b0000, 32'h0);
    chk("dir_read_only", {24'd0, gpio_oe}, 32'h00);
    xfer(5'h04, 32'h0000_FF00, 4'b0010, 32'h0);
    chk("dir_lane1", {24'd0, gpio_oe}, 32'h00);
    xfer(5'h04, 32'hFFFF_FF3C, 4'b1111, 32'h0);
    chk("dir_3c", {24'd0, gpio_oe}, 32'h3C);
    xfer(5'h04, 32'd0, 4'b0000, 32'h3C);

    // Edge capture and irq on pin 3
    xfer(5'h18, 32'h0000_0008, 4'b0001, 32'h0);
    @(negedge clk);
    gpio_in = 8'h08;
    @(posedge clk); #1;
    chk("irq_after_k", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_after_k1", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    chk("irq_after_k2", {31'd0, irq}, 32'd1);
    xfer(5'h08, 32'd0, 4'b0000, 32'h08);
    xfer(5'h1C, 32'd0, 4'b0000, 32'h08);
    xfer(5'h1C, 32'h0000_0008, 4'b0001, 32'h0);
    chk("irq_w1c", {31'd0, irq}, 32'd0);

    // Disabled pin: captured in IRQ_ST, no irq
    @(negedge clk);
    gpio_in = 8'h09;
    repeat (4) @(posedge clk);
    #1;
    chk("irq_gated", {31'd0, irq}, 32'd0);
    xfer(5'h1C, 32'd0, 4'b0000, 32'h01);
    xfer(5'h1C, 32'h0000_0001, 4'b0001, 32'h0);

    // W1C colliding with a new rise on bit 3: the set wins
    @(negedge clk);
    gpio_in = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("irq_fall_none", {31'd0, irq}, 32'd0);
    @(negedge clk);
    gpio_in = 8'h08;
    @(posedge clk);
    @(posedge clk);
    xfer(5'h1C, 32'h0000_0008, 4'b0001, 32'h0);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    xfer(5'h1C, 32'd0, 4'b0000, 32'h08);
    xfer(5'h1C, 32'h0000_0008, 4'b0001, 32'h0);
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Miss: one past the window
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h20;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b1111;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.mem_ready) seen = 1'b1;
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    chk("miss_no_ready", {31'd0, seen}, 32'd0);
    chk("miss_out", {24'd0, gpio_out}, 32'hD1);
    chk("miss_oe", {24'd0, gpio_oe}, 32'h3C);
    xfer(5'h00, 32'd0, 4'b0000, 32'hD1);

    // Reset during ACK
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE;
    bus.mem_wdata = 32'h55;
    bus.mem_wstrb = 4'b0001;
    @(posedge clk); #1;
    chk("ack_before_reset", {31'd0, bus.mem_ready}, 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("ready_async_drop", {31'd0, bus.mem_ready}, 32'd0);
    chk("reset_out", {24'd0, gpio_out}, 32'h0);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    gpio_in = '0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    xfer(5'h00, 32'd0, 4'b0000, 32'h0);
    xfer(5'h04, 32'd0, 4'b0000, 32'h0);
    xfer(5'h18, 32'd0, 4'b0000, 32'h0);
    xfer(5'h1C, 32'd0, 4'b0000, 32'h0);

    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
